// File: rtl/fpf_enc_arbiter_4.sv
// rtl/fpf_enc_arbiter_4.sv - round-robin share of one registered FPF encoder among four requesters
// Codewords return tagged with their source channel under downstream backpressure.

module fpf_encoder_25 #(
  parameter int DW = 17
) (
  input  logic          clock,
  input  logic [DW-1:0] datain,
  output logic [24:0]   codeout
);

  // Completions available for m remaining bits when the current run may switch value.
  function automatic logic [31:0] fpf_g(input int m);
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] t;
    a = 32'd1;
    b = 32'd2;
    if (m == 0) return 32'd1;
    for (int k = 1; k < m; k++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  function automatic logic [31:0] fpf_h(input int m);
    return (m == 0) ? 32'd1 : fpf_g(m - 1);
  endfunction

  logic [24:0] enc;

  // Unranks datain into the datain-th 25-bit word free of 010/101, in ascending order.
  always_comb begin
    logic [31:0] rem;
    logic        can_sw;
    logic        prev;
    rem    = 32'(datain);
    enc    = '0;
    can_sw = 1'b1;
    prev   = 1'b0;
    if (rem >= fpf_g(24)) begin
      enc[24] = 1'b1;
      rem     = rem - fpf_g(24);
    end
    for (int i = 23; i >= 0; i--) begin
      prev = enc[i+1];
      if (!can_sw) begin
        enc[i] = prev;
        can_sw = 1'b1;
      end else if (!prev) begin
        if (rem >= fpf_g(i)) begin
          enc[i] = 1'b1;
          rem    = rem - fpf_g(i);
          can_sw = 1'b0;
        end
      end else begin
        if (rem < fpf_h(i)) begin
          enc[i] = 1'b0;
          can_sw = 1'b0;
        end else begin
          enc[i] = 1'b1;
          rem    = rem - fpf_h(i);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    codeout <= enc;
  end

endmodule

module fpf_enc_arbiter_4 #(
  parameter int NCH = 4,
  parameter int DW  = 17
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NCH-1:0]    req_valid,
  input  logic [NCH*DW-1:0] req_data,
  output logic [NCH-1:0]    req_ready,
  output logic              out_valid,
  output logic [1:0]        out_ch,
  output logic [24:0]       out_code,
  input  logic              out_ready
);

  logic          a_valid;
  logic [1:0]    a_ch;
  logic [DW-1:0] a_data;
  logic          b_valid;
  logic [1:0]    b_ch;
  logic [DW-1:0] b_data;
  logic [1:0]    ptr;

  logic          advance;
  logic          load_a;
  logic          win_found;
  logic [1:0]    win_ch;
  logic [DW-1:0] win_data;
  logic [DW-1:0] enc_in;
  logic [24:0]   codeout;

  assign advance = !b_valid || out_ready;
  assign load_a  = !a_valid || advance;

  always_comb begin
    logic [1:0] idx;
    win_found = 1'b0;
    win_ch    = 2'd0;
    win_data  = '0;
    idx       = 2'd0;
    for (int i = 0; i < NCH; i++) begin
      idx = ptr + 2'(i);
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_ch    = idx;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (win_ch == 2'(i)) win_data = req_data[i*DW +: DW];
    end
  end

  always_comb begin
    req_ready = '0;
    if (load_a && !reset && win_found) req_ready = NCH'(1) << win_ch;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_valid <= 1'b0;
      a_ch    <= 2'd0;
      a_data  <= '0;
      b_valid <= 1'b0;
      b_ch    <= 2'd0;
      b_data  <= '0;
      ptr     <= 2'd0;
    end else begin
      if (advance) begin
        b_valid <= a_valid;
        b_ch    <= a_ch;
        b_data  <= a_data;
      end
      if (load_a) begin
        a_valid <= win_found;
        if (win_found) begin
          a_ch   <= win_ch;
          a_data <= win_data;
          ptr    <= win_ch + 2'd1;
        end
      end
    end
  end

  // Re-encoding b_data while stalled keeps codeout aligned with stage B.
  assign enc_in = advance ? a_data : b_data;

  fpf_encoder_25 #(.DW(DW)) u_enc (
    .clock   (clock),
    .datain  (enc_in),
    .codeout (codeout)
  );

  assign out_valid = b_valid;
  assign out_ch    = b_ch;
  assign out_code  = b_valid ? codeout : 25'd0;

endmodule

// File: doc/fpf_enc_arbiter_4.md
# fpf_enc_arbiter_4

Round-robin scheduler that shares one `FPF_encoder_25` instance among four requesters. Each requester offers a `FBLEN25`-bit binary value with a valid/ready handshake. The block sequences the values through the single registered encoder and returns each 25-bit forbidden-pattern-free codeword tagged with its source channel, under downstream backpressure. It sits between the per-lane data producers and the TSV/bus driver stage.

## Interface
- `NCH`, 4: number of requesters. Fixed at 4 for this revision; the channel tag is 2 bits.
- `DW`, `` `FBLEN25 `` (from `FNS.vh`): binary input width per channel.
- Ports:
  - `clock`  in  1  single clock; all state updates on its rising edge.
  - `reset`  in  1  synchronous, active-high reset.
  - `req_valid`  in  4  per-channel request valid.
  - `req_data`  in  4*DW  channel k occupies bits [k*DW +: DW].
  - `req_ready`  out  4  one-hot grant; a transfer on channel k occurs when `req_valid[k] & req_ready[k]`.
  - `out_valid`  out  1  codeword valid.
  - `out_ch`  out  2  source channel of `out_code`.
  - `out_code`  out  25  FPF codeword; 0 when `out_valid` is 0.
  - `out_ready`  in  1  downstream accept.

## Operation
- Pipeline registers:
  - Stage A: `a_valid`, `a_ch`, `a_data`.
  - Stage B: `b_valid`, `b_ch`, `b_data`. Stage B's codeword is the encoder's `codeout` register.
- `advance = !b_valid | out_ready`.
- Encoder `datain = advance ? a_data : b_data`.
  - This guarantees `codeout == encode(b_data)` at all times, including during stalls.
- On an edge with `advance`: `b_valid <= a_valid`, `b_ch <= a_ch`, `b_data <= a_data`.
- Stage A load enable: `load_a = !a_valid | advance`.
  - On `load_a`: if any `req_valid`, A takes the winner (`a_valid <= 1`, its channel and data). Otherwise `a_valid <= 0`.
  - Without `load_a`: A holds.
- Arbitration (combinational):
  - Round-robin over `req_valid`, starting at pointer `ptr` (2 bits).
  - Winner = first asserted channel at or after `ptr`, wrapping 3→0.
  - `req_ready = load_a ? onehot(winner) : 0`. `req_ready` depends combinationally on `req_valid`; requesters must not make valid depend on ready.
  - On a completed transfer from channel k: `ptr <= (k+1) mod 4`. Otherwise `ptr` holds.
- Outputs:
  - `out_valid = b_valid`.
  - `out_ch = b_ch`.
  - `out_code = b_valid ? codeout : 0`.
- Data range: values must be below the FPF codeword count. Out-of-range values are the requester's error; the block passes them through without checking.
- Ordering: codewords emerge strictly in grant order; no reordering or dropping.

## Timing
- Reset values:
  - `req_ready` = 0 during reset.
  - `out_valid` = 0, `out_ch` = 0, `out_code` = 0.
  - `ptr` = 0; `a_valid` and `b_valid` = 0.
  - The encoder's internal register is not reset and is masked by `out_valid`.
- First cycle after reset: `req_ready` can assert, since `a_valid` = 0.
- Latency: a transfer at edge E0 puts the codeword on the output after edge E1, i.e. `out_valid` is high in the cycle following E1.
- Throughput: one word per clock with `out_ready` held high.
- Backpressure:
  - With `out_valid` high and `out_ready` low, `out_code` and `out_ch` stay stable.
  - A can still fill if empty; after that `req_ready` = 0 until `out_ready`.
  - Capacity is 2 words in flight.
- Simultaneous events:
  - A drains to B and refills from a requester on the same edge.
  - Output handoff and B refill also happen on the same edge.
- Reset mid-operation: words in flight are discarded, with no partial output. `out_valid` drops the cycle after the reset edge; `ptr` returns to 0.

## Test plan
- Reset, then only channel 2 valid with data 1, `out_ready` = 1 → `req_ready` = 4'b0100. Two edges later: `out_valid` = 1, `out_ch` = 2, `out_code` = 25'h0000001.
- All four channels valid continuously with data 0, 1, 0, 1, `out_ready` = 1 → grants 0,1,2,3,0,… one per cycle. Output is `out_ch` 0,1,2,3 with codes 0, 1, 0, 1 back-to-back.
- `out_ready` low for 5 cycles with all channels valid → exactly 2 transfers accepted, then `req_ready` = 0. `out_code`/`out_ch` stay stable throughout. Releasing `out_ready` gives in-order delivery with no loss or duplication.
- Random 4-channel traffic with random `out_ready`, 10k words, values drawn from the legal range → every output matches the reference FPF model of the corresponding input, in grant order. No channel waits more than 3 grants while valid.
- Reset asserted while 2 words are in flight → `out_valid` = 0 the next cycle and `ptr` = 0. The next request from channel 3 is granted immediately, and only its codeword appears.
- Channels 1 and 3 valid, `ptr` = 2 → channel 3 wins, then `ptr` = 0 → channel 1 wins next.
